dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
// - Load/store sequencer between the core's memory stage and the data-memory lpm_ram_dq.
// - Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word-wide RAM cycles.
// - Sub-word stores use read-modify-write; loads are sign/zero-extended.
// - The RAM has one address port and a registered read, so every read takes one extra cycle.
// PARAMETERS
// - ADDR_WIDTH  8  RAM word-address width; drives LPM_WIDTHAD. Byte address bits [ADDR_WIDTH+1:2] are used.
// PORTS
// - clk          in   1           Sole clock; also drives the RAM inclock/outclock.
// - rst_n        in   1           Asynchronous, active-low reset.
// - req_valid    in   1           A request is presented.
// - req_ready    out  1           The controller can accept a request (state IDLE).
// - req_we       in   1           1 = store, 0 = load.
// - req_funct3   in   3           RV32I funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU).
// - req_addr     in   32          Byte address.
// - req_wdata    in   32          Store data; the value is in the low bits for B/H.
// - resp_valid   out  1           One-cycle pulse when the access completes. No backpressure.
// - resp_rdata   out  32          Extended load data; 0 for stores and errors.
// - resp_err     out  1           Misaligned access or illegal funct3 (see DMEM_ERR_EN).
// - ram_address  out  ADDR_WIDTH  Word address to the RAM.
// - ram_data     out  32          Write data to the RAM.
// - ram_we       out  1           RAM write enable; decoded from the state only.
// - ram_q        in   32          RAM registered read data.
// BEHAVIOUR
// - FSM states:
//   - IDLE: req_ready=1. Accept on req_valid. Latch addr, funct3, wdata, we.
//     - Error -> ERR.
//     - Store word -> WRITE.
//     - Any other access -> READ.
//   - READ: ram_address = latched word address, ram_we=0 -> DATA.
//   - DATA: ram_q is valid this cycle.
//     - Load: register the extended result and pulse resp_valid next cycle -> IDLE.
//     - Sub-word store: register the merged word -> WRITE.
//   - WRITE: ram_we=1, ram_data = merged or full word -> IDLE, resp_valid pulses next cycle.
//   - ERR: no RAM access -> IDLE. resp_valid=1 and resp_err=1 next cycle.
// - Latency, counted from the accept edge to the resp_valid cycle:
//   - LW/LB/LH: 3.
//   - SW: 2.
//   - SB/SH: 4.
//   - Error: 2.
// - Back-to-back requests:
//   - A new request may be accepted in the same cycle that resp_valid is high.
//   - Responses stay in order, because only one request is in flight at a time.
// - Byte lanes:
//   - The lane is addr[1:0]; halfwords use addr[1].
//   - Loads: LB/LH sign-extend, LBU/LHU zero-extend.
//   - Stores: only the lanes being stored change; the other lanes keep the RAM value read in DATA.
// - Misalignment:
//   - LH/LHU/SH with addr[0]=1 are misaligned.
//   - Word accesses with addr[1:0]!=0 are misaligned.
//   - Illegal funct3: 3, 6, 7; for stores, also 4 and 5.
// - Addresses: bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the RAM size.
// - Reset values:
//   - State = IDLE.
//   - resp_valid = 0, resp_err = 0, resp_rdata = 0.
//   - ram_we = 0.
//   - ram_address and ram_data = 0.
// - Reset mid-operation:
//   - An in-flight access is dropped and no response is issued.
//   - ram_we falls to 0 asynchronously. A WRITE cut by reset may or may not have committed.
// CONFIGURATION
// - DMEM_ERR_EN defined: misaligned or illegal requests take the ERR path described above.
// - DMEM_ERR_EN undefined:
//   - The address is forced aligned: addr[0] is cleared for halfwords, addr[1:0] for words.
//   - Illegal funct3 is treated as W.
//   - resp_err is tied to 0 and the ERR state is not built.
// STRUCTURE
// - Package dmem_pkg:
//   - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
//   - typedef enum dmem_state_e {IDLE, READ, DATA, WRITE, ERR}.
//   - Constant XLEN=32.
// - Sub-module dmem_lane_align (combinational), holding all lane logic:
//   - load extract/extend from (ram_q, offset, funct3);
//   - store merge from (ram_q, wdata, offset, funct3).
// TESTING
// 1. SW 0x12345678 @0x10, then LW @0x10 -> ram_we for 1 cycle at word 4; resp_rdata=0x12345678, load latency 3.
// 2. Word 4=0x12345678; SB 0xAB @0x11 -> exactly one ram_we cycle, data 0x1234AB78; LB @0x11 -> 0xFFFFFFAB; LBU -> 0x000000AB.
// 3. SH 0x8001 @0x12 on 0x1234AB78 -> 0x8001AB78; LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001.
// 4. DMEM_ERR_EN: LW @0x13 -> ram_we=0, READ never entered, resp_err=1 at latency 2, rdata=0. Without the macro: reads word 4, resp_err=0.
// 5. req_valid held high across SB, LW, SW -> accept cycles 0, 4, 7; one resp_valid per request, in order; req_ready low while busy.
// 6. rst_n low during the WRITE of an SB -> ram_we 0 immediately, no resp_valid; after release req_ready=1 and an LW completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory load/store sequencer.
// Contents: XLEN, RV32I load/store funct3 codes, the sequencer state enum and a
// funct3 legality helper used by the request decoder.
package dmem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, ERR} dmem_state_e;

  // Unsigned sub-word variants only exist for loads.
  function automatic logic f3Legal(input logic isStore, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3Legal = 1'b1;
      F3_BU, F3_HU:     f3Legal = !isStore;
      default:          f3Legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane logic for the data-memory sequencer.
// Ports:
//   ram_q_i      in  32  word read from the RAM
//   wdata_i      in  32  store data, value in the low bits for B/H
//   offset_i     in  2   byte offset inside the word (addr[1:0])
//   funct3_i     in  3   RV32I load/store funct3
//   load_data_o  out 32  selected lane, sign/zero-extended
//   store_data_o out 32  RAM word with only the stored lanes replaced
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [XLEN-1:0] ram_q_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] load_data_o,
  output logic [XLEN-1:0] store_data_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Halfwords are always aligned here, so offset_i[1] alone picks the half.
  always_comb begin
    laneByte = ram_q_i[{offset_i, 3'b000} +: 8];
    laneHalf = offset_i[1] ? ram_q_i[31:16] : ram_q_i[15:0];
    case (funct3_i)
      F3_B:    load_data_o = {{24{laneByte[7]}}, laneByte};
      F3_BU:   load_data_o = {24'd0, laneByte};
      F3_H:    load_data_o = {{16{laneHalf[15]}}, laneHalf};
      F3_HU:   load_data_o = {16'd0, laneHalf};
      default: load_data_o = ram_q_i;
    endcase
  end

  // Start from the word read back and overwrite only the stored lanes.
  always_comb begin
    store_data_o = ram_q_i;
    case (funct3_i[1:0])
      2'b00: store_data_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      2'b01: begin
        if (offset_i[1]) store_data_o[31:16] = wdata_i[15:0];
        else             store_data_o[15:0]  = wdata_i[15:0];
      end
      default: store_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store sequencer between the core memory stage and a
// single-port data RAM with registered read. Sub-word stores are done as
// read-modify-write; loads are sign/zero-extended.
// Configuration macro: DMEM_ERR_EN
//   defined   -> misaligned / illegal-funct3 requests complete through ERR with resp_err=1
//   undefined -> addresses are forced aligned, illegal funct3 acts as W, resp_err=0
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3       store flag and RV32I access width
//   req_addr, req_wdata      byte address and store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data, error flag
//   ram_address, ram_data    RAM word address and write data
//   ram_we                   RAM write enable (high only in WRITE)
//   ram_q                    RAM registered read data
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [XLEN-1:0]       ram_data,
  output logic                  ram_we,
  input  logic [XLEN-1:0]       ram_q
);

  localparam int BA = ADDR_WIDTH + 2;

  dmem_state_e     state_q, state_d;
  logic [BA-1:0]   addr_q;
  logic [2:0]      funct3_q;
  logic            isStore_q;
  logic [XLEN-1:0] wordData_q;
  logic            respValid_q;
  logic [XLEN-1:0] respRdata_q;

  logic [BA-1:0]   reqAddrEff;
  logic [2:0]      reqF3Eff;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] storeData;

  // Address bits above the RAM size are ignored so accesses wrap.
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[XLEN-1:BA];

`ifdef DMEM_ERR_EN
  logic reqErr;
  logic respErr_q;

  always_comb begin
    reqAddrEff = req_addr[BA-1:0];
    reqF3Eff   = req_funct3;
    reqErr     = !f3Legal(req_we, req_funct3)
               || (req_funct3[1:0] == 2'b01 && req_addr[0])
               || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  end
`else
  // Without error reporting the request is coerced into something legal.
  always_comb begin
    reqF3Eff   = f3Legal(req_we, req_funct3) ? req_funct3 : F3_W;
    reqAddrEff = req_addr[BA-1:0];
    if (reqF3Eff[1:0] == 2'b01)      reqAddrEff[0]   = 1'b0;
    else if (reqF3Eff[1:0] == 2'b10) reqAddrEff[1:0] = 2'b00;
  end
`endif

  dmem_lane_align u_lane_align (
    .ram_q_i      (ram_q),
    .wdata_i      (wordData_q),
    .offset_i     (addr_q[1:0]),
    .funct3_i     (funct3_q),
    .load_data_o  (loadData),
    .store_data_o (storeData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ram_we comes from the state alone so reset drops it immediately.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef DMEM_ERR_EN
          if (reqErr)                          state_d = ERR;
          else
`endif
          if (req_we && reqF3Eff == F3_W)      state_d = WRITE;
          else                                 state_d = READ;
        end
      end
      READ:    state_d = DATA;
      DATA:    state_d = isStore_q ? WRITE : IDLE;
      WRITE: begin
        ram_we  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, merged store word and the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      funct3_q    <= '0;
      isStore_q   <= 1'b0;
      wordData_q  <= '0;
      respValid_q <= 1'b0;
      respRdata_q <= '0;
`ifdef DMEM_ERR_EN
      respErr_q   <= 1'b0;
`endif
    end else begin
      respValid_q <= 1'b0;
      respRdata_q <= '0;
`ifdef DMEM_ERR_EN
      respErr_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= reqAddrEff;
            funct3_q   <= reqF3Eff;
            isStore_q  <= req_we;
            wordData_q <= req_wdata;
          end
        end
        DATA: begin
          if (isStore_q) begin
            wordData_q <= storeData;
          end else begin
            respValid_q <= 1'b1;
            respRdata_q <= loadData;
          end
        end
        WRITE: respValid_q <= 1'b1;
`ifdef DMEM_ERR_EN
        ERR: begin
          respValid_q <= 1'b1;
          respErr_q   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign resp_valid  = respValid_q;
  assign resp_rdata  = respRdata_q;
`ifdef DMEM_ERR_EN
  assign resp_err    = respErr_q;
`else
  assign resp_err    = 1'b0;
`endif
  assign ram_address = addr_q[BA-1:2];
  assign ram_data    = wordData_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. A word-array memory model
// predicts every response, its cycle, and every RAM write; a compare process
// checks the DUT against it each cycle. Honours DMEM_ERR_EN like the RTL.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_we;
  logic [31:0] ram_q;

  dmem_ctrl #(.ADDR_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_we      (ram_we),
    .ram_q       (ram_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          respCyc;
    logic        err;
    logic [31:0] rdata;
    logic        isWrite;
    logic [7:0]  wAddr;
    logic [31:0] wData;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] refMem [256];
  logic [31:0] ramArr [256];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          running = 0;

  // The RAM itself: one address port, registered read.
  always @(posedge clk) begin
    if (ram_we) ramArr[ram_address] <= ram_data;
    ram_q <= ramArr[ram_address];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
    checks++;
    if (act !== expVal) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expVal, cyc);
    end
  endtask

  // Memory-level model of one accepted request: updates refMem and returns
  // what the DUT must show and when (cycles counted from the accept cycle).
  task automatic modelAccept(input logic we, input logic [2:0] f3In, input logic [31:0] addrIn,
                             input logic [31:0] wd, output exp_t e);
    logic [2:0]  f3;
    logic [31:0] a, word, v, mask, newWord;
    logic        legal;
    int          w, sh;
    f3 = f3In;
    a  = addrIn;
    e  = '{default: 0};
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef DMEM_ERR_EN
    if (!legal || (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0)) begin
      e.err     = 1'b1;
      e.respCyc = cyc + 2;
      return;
    end
`else
    if (!legal) f3 = 3'd2;
    if (f3[1:0] == 2'd1) a[0] = 1'b0;
    if (f3[1:0] == 2'd2) a[1:0] = 2'd0;
`endif
    w    = int'(a[9:2]);
    sh   = 8 * int'(a[1:0]);
    word = refMem[w];
    if (!we) begin
      v = word >> sh;
      case (f3)
        3'd0: e.rdata = (v & 32'hFF) | (v[7] ? 32'hFFFFFF00 : 32'h0);
        3'd4: e.rdata = v & 32'hFF;
        3'd1: e.rdata = (v & 32'hFFFF) | (v[15] ? 32'hFFFF0000 : 32'h0);
        3'd5: e.rdata = v & 32'hFFFF;
        default: e.rdata = word;
      endcase
      e.respCyc = cyc + 3;
    end else begin
      if (f3 == 3'd2) begin
        newWord   = wd;
        e.respCyc = cyc + 2;
      end else begin
        mask      = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
        newWord   = (word & ~mask) | ((wd << sh) & mask);
        e.respCyc = cyc + 4;
      end
      refMem[w] = newWord;
      e.isWrite = 1'b1;
      e.wAddr   = a[9:2];
      e.wData   = newWord;
    end
  endtask

  // Holds the request until the handshake, then records the prediction.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, output int acc, output exp_t e);
    int waited = 0;
    acc = -1;
    e   = '{default: 0};
    while (1) begin
      @(negedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      if (req_ready) begin
        modelAccept(we, f3, addr, wd, e);
        expQ.push_back(e);
        acc = cyc;
        break;
      end
      waited++;
      if (waited > 20) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  bit expReady, expWe, expValid;

  // Every cycle out of reset: handshake, RAM write and response against the model.
  always @(negedge clk) begin
    if (running && rst_n) begin
      expReady = (expQ.size() == 0) || (expQ[0].respCyc <= cyc);
      checkOutput("req_ready", req_ready, expReady);
      expWe = (expQ.size() > 0) && expQ[0].isWrite && (expQ[0].respCyc - 1 == cyc);
      checkOutput("ram_we", ram_we, expWe);
      if (expWe) begin
        checkOutput("ram_address", ram_address, expQ[0].wAddr);
        checkOutput("ram_data", ram_data, expQ[0].wData);
      end
      expValid = (expQ.size() > 0) && (expQ[0].respCyc == cyc);
      checkOutput("resp_valid", resp_valid, expValid);
      if (expValid) begin
        checkOutput("resp_rdata", resp_rdata, expQ[0].rdata);
        checkOutput("resp_err", resp_err, expQ[0].err);
        void'(expQ.pop_front());
      end
    end
  end

  exp_t        e;
  int          accA, accB, accC;
  logic [31:0] oldWord;
  logic        rWe;
  logic [2:0]  rF3;
  logic [31:0] rAddr, rWd;
  int          drainWait;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    ram_q      = 32'd0;
    for (int i = 0; i < 256; i++) begin
      refMem[i] = 32'd0;
      ramArr[i] = 32'd0;
    end

    #12;
    checkOutput("reset_resp_valid", resp_valid, 32'd0);
    checkOutput("reset_resp_err", resp_err, 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset_ram_we", ram_we, 32'd0);
    checkOutput("reset_ram_address", ram_address, 32'd0);
    checkOutput("reset_ram_data", ram_data, 32'd0);
    checkOutput("reset_req_ready", req_ready, 32'd1);

    @(negedge clk);
    #1;
    rst_n   = 1'b1;
    running = 1'b1;

    // Word store then load back.
    applyStimulus(1'b1, F3_W, 32'h10, 32'h12345678, accA, e);
    checkOutput("t1_sw_latency", e.respCyc - accA, 32'd2);
    checkOutput("t1_sw_word", e.wData, 32'h12345678);
    applyStimulus(1'b0, F3_W, 32'h10, 32'h0, accA, e);
    checkOutput("t1_lw_latency", e.respCyc - accA, 32'd3);
    checkOutput("t1_lw_data", e.rdata, 32'h12345678);

    // Byte store read-modify-write, then signed/unsigned byte loads.
    applyStimulus(1'b1, F3_B, 32'h11, 32'h123456AB, accA, e);
    checkOutput("t2_sb_latency", e.respCyc - accA, 32'd4);
    checkOutput("t2_sb_word", e.wData, 32'h1234AB78);
    applyStimulus(1'b0, F3_B, 32'h11, 32'h0, accA, e);
    checkOutput("t2_lb_data", e.rdata, 32'hFFFFFFAB);
    applyStimulus(1'b0, F3_BU, 32'h11, 32'h0, accA, e);
    checkOutput("t2_lbu_data", e.rdata, 32'h000000AB);

    // Halfword store in the upper half, then signed/unsigned halfword loads.
    applyStimulus(1'b1, F3_H, 32'h12, 32'h00008001, accA, e);
    checkOutput("t3_sh_word", e.wData, 32'h8001AB78);
    applyStimulus(1'b0, F3_H, 32'h12, 32'h0, accA, e);
    checkOutput("t3_lh_data", e.rdata, 32'hFFFF8001);
    applyStimulus(1'b0, F3_HU, 32'h12, 32'h0, accA, e);
    checkOutput("t3_lhu_data", e.rdata, 32'h00008001);

    // Misaligned word load.
    applyStimulus(1'b0, F3_W, 32'h13, 32'h0, accA, e);
`ifdef DMEM_ERR_EN
    checkOutput("t4_err_flag", e.err, 32'd1);
    checkOutput("t4_err_latency", e.respCyc - accA, 32'd2);
    checkOutput("t4_err_data", e.rdata, 32'd0);
`else
    checkOutput("t4_err_flag", e.err, 32'd0);
    checkOutput("t4_err_latency", e.respCyc - accA, 32'd3);
    checkOutput("t4_err_data", e.rdata, 32'h8001AB78);
`endif

    // Back-to-back with req_valid held: SB, LW, SW.
    applyStimulus(1'b1, F3_B, 32'h20, 32'h55, accA, e);
    applyStimulus(1'b0, F3_W, 32'h20, 32'h0, accB, e);
    checkOutput("t5_lw_data", e.rdata, 32'h00000055);
    applyStimulus(1'b1, F3_W, 32'h24, 32'hCAFEF00D, accC, e);
    checkOutput("t5_accept_gap1", accB - accA, 32'd4);
    checkOutput("t5_accept_gap2", accC - accB, 32'd3);

    // Reset while an SB is in its WRITE cycle.
    idleCycles(4);
    refMem[12] = 32'hA5A5A5A5;
    applyStimulus(1'b1, F3_W, 32'h30, 32'hA5A5A5A5, accA, e);
    idleCycles(3);
    oldWord = refMem[12];
    applyStimulus(1'b1, F3_B, 32'h31, 32'h000000CC, accA, e);
    repeat (3) @(negedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("t6_ram_we_async", ram_we, 32'd0);
    checkOutput("t6_resp_valid", resp_valid, 32'd0);
    expQ.delete();
    idleCycles(2);
    checkOutput("t6_no_resp", resp_valid, 32'd0);
    checkOutput("t6_commit_either", (ramArr[12] == oldWord) || (ramArr[12] == e.wData), 32'd1);
    refMem[12] = ramArr[12];
    rst_n = 1'b1;
    applyStimulus(1'b0, F3_W, 32'h10, 32'h0, accA, e);
    checkOutput("t6_lw_after_reset", e.rdata, 32'h8001AB78);

    // Randomized traffic over 16 words with random high address bits.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      rWe        = 1'($urandom_range(0, 1));
      rF3        = 3'($urandom_range(0, 7));
      rAddr      = $urandom;
      rAddr[9:2] = 8'($urandom_range(0, 15));
      rWd        = $urandom;
      applyStimulus(rWe, rF3, rAddr, rWd, accA, e);
    end
    idleCycles(1);

    drainWait = 0;
    while (expQ.size() != 0 && drainWait < 50) begin
      @(negedge clk);
      drainWait++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 32'd0);
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
